// File: rtl/audio_tracker_synth.sv
// N-voice tracker synthesiser: beat sequencer, per-voice phase/envelope/noise,
// voice mixer, one-pole low-pass filter and first-order sigma-delta PWM pin.
module audio_tracker_synth #(
    parameter int NUM_VOICES     = 3,
    parameter int PHASE_W        = 16,
    parameter int VOL_W          = 6,
    parameter int SONG_LEN       = 288,
    parameter int TICKS_PER_BEAT = 6,
    parameter int DECAY_SHIFT    = 3,
    parameter int LPF_SHIFT      = 3,
    localparam int POS_W = $clog2(SONG_LEN),
    localparam int MIX_W = VOL_W + $clog2(NUM_VOICES + 1),
    localparam int LVL_W = MIX_W + LPF_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    sample_tick,
    input  logic                    frame_tick,
    input  logic [NUM_VOICES-1:0]   voice_trig,
    input  logic [8*NUM_VOICES-1:0] voice_inc,
    input  logic [2*NUM_VOICES-1:0] voice_oct,
    input  logic [2*NUM_VOICES-1:0] voice_wave,
    input  logic [NUM_VOICES-1:0]   mute,
    output logic [POS_W-1:0]        song_pos,
    output logic                    beat,
    output logic [LVL_W-1:0]        level,
    output logic                    pwm_out
);
    localparam int TICK_W      = $clog2(TICKS_PER_BEAT + 1);
    localparam int SWP_W       = 9;
    localparam int SWEEP_SHIFT = 3;
    localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};

    logic [POS_W-1:0]  song_pos_q, song_pos_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              beat_q, beat_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [LVL_W-1:0]  acc_q, acc_d;
    logic              pwm_q, pwm_d;
    logic [NUM_VOICES-1:0][PHASE_W-1:0] phase_q, phase_d;
    logic [NUM_VOICES-1:0][VOL_W-1:0]   vol_q, vol_d;
    logic [NUM_VOICES-1:0][SWP_W-1:0]   sweep_q, sweep_d;
    logic [NUM_VOICES-1:0][14:0]        lfsr_q, lfsr_d;
    logic [NUM_VOICES-1:0][VOL_W-1:0]   smp_s;
    logic [MIX_W-1:0]  mix_s;
    logic              tick_s, samp_s, beat_s;

    // Shifting left by the octave brings phase[PHASE_W-1-oct] to the MSB.
    function automatic logic voice_on(input logic [PHASE_W-1:0] ph, input logic [1:0] oct,
                                      input logic [1:0] wave, input logic noise_bit);
        logic [PHASE_W-1:0] sh;
        logic               on;
        sh = ph << oct;
        case (wave)
            2'd0:    on = sh[PHASE_W-1];
            2'd1:    on = sh[PHASE_W-1] & sh[PHASE_W-2];
            2'd2:    on = noise_bit;
            2'd3:    on = ph[PHASE_W-1];
            default: on = 1'b0;
        endcase
        return on;
    endfunction

    // Per-voice gated samples and their sum, taken from registered state.
    always_comb begin
        smp_s = '0;
        mix_s = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_on(phase_q[v], voice_oct[2*v +: 2], voice_wave[2*v +: 2], lfsr_q[v][0])
                && !mute[v]) begin
                smp_s[v] = vol_q[v];
            end else begin
                smp_s[v] = '0;
            end
            mix_s = mix_s + MIX_W'(smp_s[v]);
        end
    end

    // Next-state logic for sequencer, voices, filter and sigma-delta modulator.
    always_comb begin
        tick_s     = frame_tick & run;
        samp_s     = sample_tick & run;
        beat_s     = tick_s && (tick_q == TICK_W'(TICKS_PER_BEAT - 1));
        tick_d     = tick_q;
        song_pos_d = song_pos_q;
        phase_d    = phase_q;
        vol_d      = vol_q;
        sweep_d    = sweep_q;
        lfsr_d     = lfsr_q;
        if (beat_s) begin
            tick_d     = '0;
            song_pos_d = (song_pos_q == POS_W'(SONG_LEN - 1)) ? '0 : song_pos_q + POS_W'(1);
        end else if (tick_s) begin
            tick_d = tick_q + TICK_W'(1);
        end else begin
            tick_d = tick_q;
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (samp_s) begin
                phase_d[v] = phase_q[v] + ((voice_wave[2*v +: 2] == 2'd3) ?
                             PHASE_W'(sweep_q[v]) : PHASE_W'(voice_inc[8*v +: 8]));
                lfsr_d[v]  = {lfsr_q[v][0] ^ lfsr_q[v][1], lfsr_q[v][14:1]};
            end else begin
                phase_d[v] = phase_q[v];
            end
            // A trigger's phase reset wins over the same-cycle phase advance.
            if (beat_s && voice_trig[v]) begin
                vol_d[v]   = VOL_MAX;
                phase_d[v] = '0;
                if (voice_wave[2*v +: 2] == 2'd3) begin
                    sweep_d[v] = {voice_inc[8*v +: 8], 1'b0};
                end else begin
                    sweep_d[v] = sweep_q[v];
                end
            end else if (tick_s && !beat_s) begin
                vol_d[v] = vol_q[v] - (vol_q[v] >> DECAY_SHIFT);
                if (voice_wave[2*v +: 2] == 2'd3) begin
                    sweep_d[v] = sweep_q[v] - (sweep_q[v] >> SWEEP_SHIFT);
                end else begin
                    sweep_d[v] = sweep_q[v];
                end
            end else begin
                vol_d[v] = vol_q[v];
            end
        end
        if (samp_s) begin
            level_d = level_q + LVL_W'(mix_s) - (level_q >> LPF_SHIFT);
        end else begin
            level_d = level_q;
        end
        {pwm_d, acc_d} = {1'b0, acc_q} + {1'b0, level_q};
        beat_d = beat_s;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            song_pos_q <= POS_W'(SONG_LEN - 1);
            tick_q     <= '0;
            beat_q     <= 1'b0;
            level_q    <= '0;
            acc_q      <= '0;
            pwm_q      <= 1'b0;
            phase_q    <= '0;
            vol_q      <= '0;
            sweep_q    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                lfsr_q[v] <= 15'h4001 ^ 15'(v);
            end
        end else begin
            song_pos_q <= song_pos_d;
            tick_q     <= tick_d;
            beat_q     <= beat_d;
            level_q    <= level_d;
            acc_q      <= acc_d;
            pwm_q      <= pwm_d;
            phase_q    <= phase_d;
            vol_q      <= vol_d;
            sweep_q    <= sweep_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign song_pos = song_pos_q;
    assign beat     = beat_q;
    assign level    = level_q;
    assign pwm_out  = pwm_q;
endmodule

// File: tb/tb_audio_tracker_synth.sv
// Randomised scoreboard bench for audio_tracker_synth against a behavioural song/voice model.
module tb_audio_tracker_synth;
    localparam int NV = 3;
    localparam int LW = 11;
    localparam int PW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, run, sample_tick, frame_tick;
    logic [NV-1:0] voice_trig, mute;
    logic [8*NV-1:0] voice_inc;
    logic [2*NV-1:0] voice_oct, voice_wave;
    logic [PW-1:0] song_pos;
    logic          beat;
    logic [LW-1:0] level;
    logic          pwm_out;

    audio_tracker_synth dut (
        .clk(clk), .rst_n(rst_n), .run(run), .sample_tick(sample_tick),
        .frame_tick(frame_tick), .voice_trig(voice_trig), .voice_inc(voice_inc),
        .voice_oct(voice_oct), .voice_wave(voice_wave), .mute(mute),
        .song_pos(song_pos), .beat(beat), .level(level), .pwm_out(pwm_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int m_pos, m_tick, m_level, m_acc, m_pwm;
    int m_vol[NV], m_phase[NV], m_sweep[NV], m_lfsr[NV];
    bit m_beat;

    typedef struct { int cyc; int pos; } beat_t;
    beat_t beat_q[$];
    int    lvl_q[$];
    int    pwm_q[$];
    int    drv_cyc = 0;
    int    mon_cyc = 0;
    int    beat_cnt = 0;
    int    wrap_cnt = 0;

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_step();
        int mix, s, w, inc, b, on;
        bit tk, sp, isbeat;
        if (!rst_n) begin
            m_pos = 287; m_tick = 0; m_level = 0; m_acc = 0; m_pwm = 0; m_beat = 0;
            for (int v = 0; v < NV; v++) begin
                m_vol[v] = 0; m_phase[v] = 0; m_sweep[v] = 0; m_lfsr[v] = 16385 ^ v;
            end
            lvl_q.push_back(0);
        end else begin
            s = m_acc + m_level;
            m_pwm = s / 2048;
            m_acc = s % 2048;
            tk = frame_tick && run;
            sp = sample_tick && run;
            mix = 0;
            for (int v = 0; v < NV; v++) begin
                w = int'(voice_wave[2*v +: 2]);
                b = 15 - int'(voice_oct[2*v +: 2]);
                case (w)
                    0: on = (m_phase[v] >> b) & 1;
                    1: on = (m_phase[v] >> b) & (m_phase[v] >> (b - 1)) & 1;
                    2: on = m_lfsr[v] & 1;
                    default: on = (m_phase[v] >> 15) & 1;
                endcase
                if (on != 0 && !mute[v]) mix += m_vol[v];
            end
            isbeat = tk && (m_tick + 1 == 6);
            for (int v = 0; v < NV; v++) begin
                w   = int'(voice_wave[2*v +: 2]);
                inc = int'(voice_inc[8*v +: 8]);
                if (sp) begin
                    m_phase[v] = (m_phase[v] + ((w == 3) ? m_sweep[v] : inc)) % 65536;
                    m_lfsr[v]  = (m_lfsr[v] >> 1) | (((m_lfsr[v] ^ (m_lfsr[v] >> 1)) & 1) << 14);
                end
                if (isbeat && voice_trig[v]) begin
                    m_vol[v] = 63;
                    m_phase[v] = 0;
                    if (w == 3) m_sweep[v] = 2 * inc;
                end else if (tk && !isbeat) begin
                    m_vol[v] -= m_vol[v] / 8;
                    if (w == 3) m_sweep[v] -= m_sweep[v] / 8;
                end
            end
            m_beat = isbeat;
            if (isbeat) begin
                m_tick = 0;
                m_pos = (m_pos + 1) % 288;
                beat_q.push_back('{drv_cyc, m_pos});
            end else if (tk) begin
                m_tick++;
            end
            if (sp) begin
                m_level = m_level + mix - m_level / 8;
                lvl_q.push_back(m_level);
            end
        end
        pwm_q.push_back(m_pwm);
        drv_cyc++;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge clk);
            #1;
        end
    endtask

    // Pulse frame_tick until the model reports a beat (at most one beat period).
    task automatic beat_now();
        for (int i = 0; i < 6; i++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            if (m_beat) break;
            cyc(1);
        end
    endtask

    // Monitor: compares whenever the DUT presents a beat, a level update, or a PWM bit.
    initial begin
        bit    lv;
        int    idx;
        beat_t e;
        forever begin
            @(posedge clk);
            lv  = !rst_n || (sample_tick && run);
            idx = mon_cyc;
            mon_cyc++;
            @(negedge clk);
            if (beat) begin
                beat_cnt++;
                if (song_pos == 0) wrap_cnt++;
                if (beat_q.size() == 0) check("beat_spurious", 1, 0);
                else begin
                    e = beat_q.pop_front();
                    check("beat_cycle", idx, e.cyc);
                    check("beat_pos", int'(song_pos), e.pos);
                end
            end
            if (lv) begin
                if (lvl_q.size() == 0) check("level_unexpected", 1, 0);
                else check("level", int'(level), lvl_q.pop_front());
            end
            if (pwm_q.size() == 0) check("pwm_unexpected", 1, 0);
            else check("pwm_out", int'(pwm_out), pwm_q.pop_front());
        end
    end

    initial begin
        int b0, w0, lv0, p0, ones, d;
        rst_n = 1'b0; run = 1'b0; sample_tick = 1'b0; frame_tick = 1'b0;
        voice_trig = '0; mute = '0; voice_inc = '0; voice_oct = '0; voice_wave = '0;
        cyc(2);
        rst_n = 1'b1; run = 1'b1;
        check("rst_song_pos", int'(song_pos), 287);
        check("rst_beat", int'(beat), 0);
        check("rst_level", int'(level), 0);
        check("rst_pwm", int'(pwm_out), 0);

        // six ticks, no triggers: exactly one beat, position 287 -> 0
        b0 = beat_cnt;
        for (int i = 0; i < 6; i++) begin
            frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
        end
        check("first_beat_count", beat_cnt - b0, 1);
        check("first_pos", int'(song_pos), 0);
        check("silent_level", int'(level), 0);

        // square voice 0, inc 0x40, oct 0; decaying envelope with many samples
        voice_inc = {8'h00, 8'h00, 8'h40}; voice_wave = '0; voice_oct = '0;
        voice_trig = 3'b001;
        beat_now();
        voice_trig = '0;
        sample_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(299); frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        end
        sample_tick = 1'b0;

        // sweep voice 2 with inc 0xC0, ticks coinciding with samples
        voice_wave = {2'd3, 2'd1, 2'd0}; voice_inc = {8'hC0, 8'h33, 8'h40};
        voice_trig = 3'b110;
        sample_tick = 1'b1;
        beat_now();
        voice_trig = '0;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(60);
        end
        sample_tick = 1'b0;

        // randomised traffic, occasional run=0 and reset
        for (int i = 0; i < 3000; i++) begin
            run         = ($urandom_range(0, 15) != 0);
            rst_n       = ($urandom_range(0, 999) != 0);
            sample_tick = 1'($urandom_range(0, 1));
            frame_tick  = ($urandom_range(0, 5) == 0);
            voice_trig  = 3'($urandom);
            mute        = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            if ($urandom_range(0, 63) == 0) begin
                voice_inc  = 24'($urandom);
                voice_oct  = 6'($urandom);
                voice_wave = 6'($urandom);
            end
            cyc(1);
        end
        rst_n = 1'b1; run = 1'b1; mute = '0;

        // full song: 288 beats, exactly one wrap, position returns to start
        b0 = beat_cnt; w0 = wrap_cnt; p0 = m_pos;
        voice_trig = 3'b111;
        for (int i = 0; i < 288 * 6; i++) begin
            frame_tick = 1'b1; sample_tick = 1'b1; cyc(1);
            frame_tick = 1'b0; sample_tick = 1'b0; cyc(1);
        end
        check("song_beats", beat_cnt - b0, 288);
        check("song_wraps", wrap_cnt - w0, 1);
        check("song_pos_return", int'(song_pos), p0);

        // freeze with run=0: strobes ignored, PWM duty tracks the frozen level
        sample_tick = 1'b1; voice_trig = 3'b111; beat_now(); cyc(40);
        lv0 = m_level; p0 = m_pos;
        run = 1'b0; ones = 0;
        for (int i = 0; i < 1024; i++) begin
            sample_tick = 1'($urandom_range(0, 1));
            frame_tick  = 1'($urandom_range(0, 1));
            cyc(1);
            ones += int'(pwm_out);
        end
        sample_tick = 1'b0; frame_tick = 1'b0;
        check("freeze_level", int'(level), lv0);
        check("freeze_pos", int'(song_pos), p0);
        d = ones - lv0 / 2;
        n_cmp++;
        if (d < -1 || d > 1) begin
            n_bad++;
            $display("FAIL pwm_duty: got %0d ones in 1024, want %0d +/-1", ones, lv0 / 2);
        end

        // mid-note reset for one clock
        run = 1'b1; voice_trig = 3'b001; voice_wave = '0; sample_tick = 1'b1;
        beat_now(); cyc(30);
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        check("midrst_level", int'(level), 0);
        check("midrst_pwm", int'(pwm_out), 0);
        check("midrst_pos", int'(song_pos), 287);
        check("midrst_beat", int'(beat), 0);
        voice_trig = '0;
        cyc(20);
        sample_tick = 1'b0;
        cyc(3);
        check("beat_queue_drained", beat_q.size(), 0);
        check("level_queue_drained", lvl_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
